mem_port_arbiter: RTL

- Shares one single-ported memory between the IF stage (instruction fetch, read-only) and the MEM stage (load/store) of the five-stage core.
- Sequences one outstanding memory transaction at a time and buffers each completed result until the pipeline advances.
- Generates the inst_mem_hazard / data_mem_hazard stall requests consumed by the pipeline hazard unit.

---
 rtl/mem_port_arbiter_if.sv | 25 ++
 rtl/mem_port_arbiter.sv | 111 +++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Memory-side request/response bus of the IF/MEM port arbiter.
// master = arbiter (drives request fields), slave = memory (drives ready and response).
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    mem_req_valid;
    logic                    mem_req_ready;
    logic                    mem_we;
    logic [DATA_WIDTH/8-1:0] mem_wstrb;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic                    mem_resp_valid;
    logic [DATA_WIDTH-1:0]   mem_rdata;

    modport master (
        output mem_req_valid, mem_we, mem_wstrb, mem_addr, mem_wdata,
        input  mem_req_ready, mem_resp_valid, mem_rdata
    );

    modport slave (
        input  mem_req_valid, mem_we, mem_wstrb, mem_addr, mem_wdata,
        output mem_req_ready, mem_resp_valid, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between IF fetches and MEM loads/stores, data first.
// Latency: request seen in IDLE, issued next cycle, result bypassed on the response cycle (min 2).
// Backpressure: mem_req_ready stalls in ISSUE; clients stall via *_mem_hazard until done.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    inst_req,
    input  logic [ADDR_WIDTH-1:0]   inst_addr,
    output logic [DATA_WIDTH-1:0]   inst_rdata,
    output logic                    inst_mem_hazard,
    input  logic                    data_req,
    input  logic                    data_we,
    input  logic [DATA_WIDTH/8-1:0] data_wstrb,
    input  logic [ADDR_WIDTH-1:0]   data_addr,
    input  logic [DATA_WIDTH-1:0]   data_wdata,
    output logic [DATA_WIDTH-1:0]   data_rdata,
    output logic                    data_mem_hazard,
    mem_port_arbiter_if.master      mem
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    typedef enum logic {OWN_INST, OWN_DATA} owner_t;

    state_t                state;
    owner_t                owner;
    logic                  inst_done;
    logic                  data_done;
    logic [DATA_WIDTH-1:0] inst_buf;
    logic [DATA_WIDTH-1:0] data_buf;

    logic resp_inst;
    logic resp_data;
    logic advance;

    always_comb begin
        resp_inst       = (state == WAIT) && mem.mem_resp_valid && (owner == OWN_INST);
        resp_data       = (state == WAIT) && mem.mem_resp_valid && (owner == OWN_DATA);
        inst_mem_hazard = inst_req && !inst_done && !resp_inst;
        data_mem_hazard = data_req && !data_done && !resp_data;
        advance         = !inst_mem_hazard && !data_mem_hazard;
        inst_rdata      = resp_inst ? mem.mem_rdata : inst_buf;
        data_rdata      = resp_data ? mem.mem_rdata : data_buf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            owner             <= OWN_INST;
            inst_done         <= 1'b0;
            data_done         <= 1'b0;
            inst_buf          <= '0;
            data_buf          <= '0;
            mem.mem_req_valid <= 1'b0;
            mem.mem_we        <= 1'b0;
            mem.mem_wstrb     <= '0;
            mem.mem_addr      <= '0;
            mem.mem_wdata     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_req && !data_done) begin
                        owner             <= OWN_DATA;
                        mem.mem_we        <= data_we;
                        mem.mem_wstrb     <= data_wstrb;
                        mem.mem_addr      <= data_addr;
                        mem.mem_wdata     <= data_wdata;
                        mem.mem_req_valid <= 1'b1;
                        state             <= ISSUE;
                    end else if (inst_req && !inst_done) begin
                        owner             <= OWN_INST;
                        mem.mem_we        <= 1'b0;
                        mem.mem_wstrb     <= '0;
                        mem.mem_addr      <= inst_addr;
                        mem.mem_wdata     <= '0;
                        mem.mem_req_valid <= 1'b1;
                        state             <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem.mem_req_ready) begin
                        mem.mem_req_valid <= 1'b0;
                        state             <= WAIT;
                    end
                end
                WAIT: begin
                    // A requester that withdrew mid-flight gets nothing, so its next request refetches.
                    if (mem.mem_resp_valid) begin
                        state <= IDLE;
                        if (owner == OWN_DATA) begin
                            if (data_req) begin
                                data_done <= 1'b1;
                                data_buf  <= mem.mem_rdata;
                            end
                        end else if (inst_req) begin
                            inst_done <= 1'b1;
                            inst_buf  <= mem.mem_rdata;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            // Placed last so a flag set on the advancing edge ends up cleared.
            if (advance) begin
                inst_done <= 1'b0;
                data_done <= 1'b0;
            end
        end
    end
endmodule
